// File: rtl/hdp_timing_pkg.sv
// Shared types, default panel geometry and frame-length helper for the HDP frame timer.
package hdp_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PORCH  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_PACKETS_PER_LINE = 40;
    localparam int DEF_LINE_BLANK       = 4;
    localparam int DEF_LINES            = 1280;
    localparam int DEF_BACK_PORCH       = 24;
    localparam int DEF_UPDATE_LEN       = 28;

    function automatic int frame_len(input int lines, input int ppl, input int blank, input int porch);
        return lines * (ppl + blank) + porch;
    endfunction

endpackage

// File: rtl/hdp_sat_counter.sv
// 16-bit event counter that sticks at 0xFFFF; a synchronous clear wins over a same-cycle increment.
module hdp_sat_counter (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hdp_frame_timer.sv
// HDP frame-timing generator: pops a FWFT pixel FIFO in data slots, zero-fills on underflow.
// Optional frame-polarity toggle on o_invert is enabled by defining HDP_FRAME_INVERT_EN.
module hdp_frame_timer
    import hdp_timing_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int PACKETS_PER_LINE = DEF_PACKETS_PER_LINE,
    parameter int LINE_BLANK       = DEF_LINE_BLANK,
    parameter int LINES            = DEF_LINES,
    parameter int BACK_PORCH       = DEF_BACK_PORCH,
    parameter int UPDATE_LEN       = DEF_UPDATE_LEN
) (
    input  logic                  i_clock,
    input  logic                  i_nReset,
    input  logic                  i_enable,
    input  logic                  i_clearStats,
    input  logic [DATA_WIDTH-1:0] i_fifoData,
    input  logic                  i_fifoEmpty,
    output logic                  o_fifoRead,
    output logic [DATA_WIDTH-1:0] o_lcdData,
    output logic                  o_valid,
    output logic                  o_update,
    output logic                  o_sync,
    output logic                  o_invert,
    output logic                  o_active,
    output logic [15:0]           o_underflowCount
);

    localparam int PKT_TOTAL = PACKETS_PER_LINE + LINE_BLANK;
    localparam int FRAME_LEN = frame_len(LINES, PACKETS_PER_LINE, LINE_BLANK, BACK_PORCH);
    localparam int PKT_W     = (PKT_TOTAL > 1) ? $clog2(PKT_TOTAL) : 1;
    localparam int LINE_W    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int PORCH_W   = (BACK_PORCH > 1) ? $clog2(BACK_PORCH) : 1;
    localparam int FRAME_W   = $clog2(FRAME_LEN + 1);

    state_t               r_state;
    logic [PKT_W-1:0]     r_pkt;
    logic [LINE_W-1:0]    r_line;
    logic [PORCH_W-1:0]   r_porch;
    logic [FRAME_W-1:0]   r_frame_cnt;

    logic w_in_frame;
    logic w_slot;
    logic w_read;
    logic w_frame_start;
    logic w_update;

    assign w_in_frame    = (r_state != ST_IDLE);
    assign w_slot        = (r_state == ST_ACTIVE) && (r_pkt < PKT_W'(PACKETS_PER_LINE));
    assign w_read        = w_slot && !i_fifoEmpty;
    assign w_frame_start = w_in_frame && (r_frame_cnt == '0);
    assign w_update      = w_in_frame && (int'(r_frame_cnt) < UPDATE_LEN);

    assign o_fifoRead = w_read;
    assign o_active   = w_in_frame;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state     <= ST_IDLE;
            r_pkt       <= '0;
            r_line      <= '0;
            r_porch     <= '0;
            r_frame_cnt <= '0;
            o_lcdData   <= '0;
            o_valid     <= 1'b0;
            o_update    <= 1'b0;
            o_sync      <= 1'b0;
        end else begin
            // Outputs reflect the pre-edge counter state, one cycle behind it.
            o_lcdData <= w_read ? i_fifoData : '0;
            o_valid   <= w_slot;
            o_update  <= w_update;
            o_sync    <= w_frame_start;

            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state     <= ST_ACTIVE;
                        r_pkt       <= '0;
                        r_line      <= '0;
                        r_porch     <= '0;
                        r_frame_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                    if (r_pkt == PKT_W'(PKT_TOTAL - 1)) begin
                        r_pkt <= '0;
                        if (r_line == LINE_W'(LINES - 1)) begin
                            r_line  <= '0;
                            r_porch <= '0;
                            r_state <= ST_PORCH;
                        end else begin
                            r_line <= r_line + 1'b1;
                        end
                    end else begin
                        r_pkt <= r_pkt + 1'b1;
                    end
                end
                ST_PORCH: begin
                    if (r_porch == PORCH_W'(BACK_PORCH - 1)) begin
                        r_porch     <= '0;
                        r_frame_cnt <= '0;
                        r_state     <= i_enable ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        r_porch     <= r_porch + 1'b1;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef HDP_FRAME_INVERT_EN
    // r_inv_next holds the polarity of the next frame so frame 0 after reset reads 0.
    logic r_inv_next;
    logic r_invert;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_inv_next <= 1'b0;
            r_invert   <= 1'b0;
        end else if (w_frame_start) begin
            r_invert   <= r_inv_next;
            r_inv_next <= ~r_inv_next;
        end
    end

    assign o_invert = r_invert;
`else
    assign o_invert = 1'b0;
`endif

    hdp_sat_counter u_underflow_cnt (
        .i_clock  (i_clock),
        .i_nReset (i_nReset),
        .i_clear  (i_clearStats),
        .i_inc    (w_slot && i_fifoEmpty),
        .o_count  (o_underflowCount)
    );

endmodule

// File: tb/tb_hdp_frame_timer.sv
// Randomized and directed bench for hdp_frame_timer against a frame-position reference model.
module tb_hdp_frame_timer;

    localparam int DW  = 32;
    localparam int PPL = 4;
    localparam int LB  = 2;
    localparam int LN  = 3;
    localparam int BP  = 5;
    localparam int UL  = 7;
    localparam int PT  = PPL + LB;
    localparam int FL  = LN * PT + BP;

`ifdef HDP_FRAME_INVERT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          clr;
    logic [DW-1:0] fdata;
    logic          empty;
    logic          o_fifoRead;
    logic [DW-1:0] o_lcdData;
    logic          o_valid, o_update, o_sync, o_invert, o_active;
    logic [15:0]   o_underflowCount;

    logic          sc_clr, sc_inc;
    logic [15:0]   sc_cnt;

    always #5 clk = ~clk;

    hdp_frame_timer #(
        .DATA_WIDTH(DW), .PACKETS_PER_LINE(PPL), .LINE_BLANK(LB),
        .LINES(LN), .BACK_PORCH(BP), .UPDATE_LEN(UL)
    ) dut (
        .i_clock(clk), .i_nReset(nrst), .i_enable(en), .i_clearStats(clr),
        .i_fifoData(fdata), .i_fifoEmpty(empty), .o_fifoRead(o_fifoRead),
        .o_lcdData(o_lcdData), .o_valid(o_valid), .o_update(o_update),
        .o_sync(o_sync), .o_invert(o_invert), .o_active(o_active),
        .o_underflowCount(o_underflowCount)
    );

    hdp_sat_counter u_sc (
        .i_clock(clk), .i_nReset(nrst), .i_clear(sc_clr), .i_inc(sc_inc), .o_count(sc_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: frame position m_p within a running frame.
    bit            m_run;
    int            m_p;
    bit            m_par;
    int            m_cnt;
    logic [DW-1:0] e_data;
    bit            e_valid, e_upd, e_sync, e_inv;
    bit            obs_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_p = 0; m_par = 0; m_cnt = 0;
        e_data = '0; e_valid = 0; e_upd = 0; e_sync = 0; e_inv = 0;
    endtask

    task automatic drive(input bit e, input bit emp, input bit c);
        en    = e;
        empty = emp;
        clr   = c;
        fdata = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_read"},   32'(o_fifoRead), 32'(0));
        chk({tag, "_data"},   o_lcdData, 32'(0));
        chk({tag, "_valid"},  32'(o_valid), 32'(0));
        chk({tag, "_update"}, 32'(o_update), 32'(0));
        chk({tag, "_sync"},   32'(o_sync), 32'(0));
        chk({tag, "_invert"}, 32'(o_invert), 32'(0));
        chk({tag, "_active"}, 32'(o_active), 32'(0));
        chk({tag, "_uflow"},  32'(o_underflowCount), 32'(0));
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic cyc();
        bit slot, rd;
        #1;
        slot   = m_run && (m_p < LN * PT) && ((m_p % PT) < PPL);
        rd     = slot && !empty;
        obs_rd = o_fifoRead;
        chk("fifoRead", 32'(o_fifoRead), 32'(rd));
        e_data  = rd ? fdata : '0;
        e_valid = slot;
        e_upd   = m_run && (m_p < UL);
        e_sync  = m_run && (m_p == 0);
        if (e_sync) begin
            e_inv = INV_EN ? m_par : 1'b0;
            m_par = !m_par;
        end
        if (clr) m_cnt = 0;
        else if (slot && empty && m_cnt < 65535) m_cnt++;
        if (!m_run) begin
            if (en) begin m_run = 1; m_p = 0; end
        end else if (m_p == FL - 1) begin
            m_p = 0;
            m_run = en;
        end else begin
            m_p++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("lcdData", o_lcdData, e_data);
        chk("valid",   32'(o_valid), 32'(e_valid));
        chk("update",  32'(o_update), 32'(e_upd));
        chk("sync",    32'(o_sync), 32'(e_sync));
        chk("invert",  32'(o_invert), 32'(e_inv));
        chk("active",  32'(o_active), 32'(m_run));
        chk("uflow",   32'(o_underflowCount), 32'(m_cnt));
    endtask

    initial begin
        int pops, syncs, upds, nsync;
        bit inv_seen [4];

        nrst = 1'b0; sc_clr = 1'b0; sc_inc = 1'b0;
        drive(0, 1, 0);
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Full FIFO, enable held: pops per frame and sync cadence.
        drive(1, 0, 0); cyc();
        chk("first_valid_lag", 32'(o_valid), 32'(0));
        pops = 0;
        for (int i = 0; i < FL; i++) begin drive(1, 0, 0); cyc(); pops += int'(obs_rd); end
        chk("pops_per_frame", 32'(pops), 32'(PPL * LN));
        syncs = 0;
        for (int i = 0; i < 3 * FL; i++) begin drive(1, 0, 0); cyc(); syncs += int'(o_sync); end
        chk("syncs_3_frames", 32'(syncs), 32'(3));

        // Underflow on every slot of line 1, then clear colliding with the next underflow.
        for (int i = 0; i < FL && !(m_run && m_p == 0); i++) begin drive(1, 0, 0); cyc(); end
        drive(1, 0, 1); cyc();
        for (int i = 1; i < FL; i++) begin
            drive(1, (m_p >= PT && m_p < 2 * PT), 0); cyc();
        end
        chk("uflow_line1", 32'(o_underflowCount), 32'(PPL));
        drive(1, 1, 1); cyc();
        chk("uflow_clear_prio", 32'(o_underflowCount), 32'(0));

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0);
            cyc();
        end

        // Enable dropped at line 1: frame completes, then idle with no pops.
        for (int i = 0; i < 2 * FL + 2 && !(m_run && m_p == PT); i++) begin drive(1, 0, 0); cyc(); end
        chk("reached_line1", 32'(m_run && m_p == PT), 32'(1));
        for (int i = 0; i < FL + 5; i++) begin drive(0, 0, 0); cyc(); end
        chk("idle_after_drop", 32'(o_active), 32'(0));
        pops = 0;
        for (int i = 0; i < 10; i++) begin drive(0, 0, 0); cyc(); pops += int'(obs_rd); end
        chk("idle_no_pops", 32'(pops), 32'(0));

        // Asynchronous reset mid-line.
        for (int i = 0; i < 2 * FL + 2 && !(m_run && m_p == PT + 1); i++) begin drive(1, 0, 0); cyc(); end
        nrst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk); @(negedge clk);
        nrst = 1'b1;
        drive(1, 0, 0); cyc();
        chk("sync_not_first", 32'(o_sync), 32'(0));
        drive(1, 0, 0); cyc();
        chk("sync_second", 32'(o_sync), 32'(1));

        // Four frames: invert sequence and update width per frame.
        nsync = 0;
        upds  = int'(o_update);
        if (o_sync) begin inv_seen[0] = o_invert; nsync = 1; end
        for (int i = 1; i < 4 * FL; i++) begin
            drive(1, $urandom_range(0, 9) < 2, 0); cyc();
            upds += int'(o_update);
            if (o_sync && nsync < 4) begin inv_seen[nsync] = o_invert; nsync++; end
        end
        chk("four_syncs", 32'(nsync), 32'(4));
        for (int k = 0; k < 4; k++) chk("invert_seq", 32'(inv_seen[k]), INV_EN ? 32'(k % 2) : 32'(0));
        chk("update_cycles", 32'(upds), 32'(4 * ((UL < FL) ? UL : FL)));

        // Saturation of the underflow counter block.
        drive(0, 0, 0);
        sc_inc = 1'b1;
        for (int i = 0; i < 65540; i++) @(negedge clk);
        chk("sat_reached", 32'(sc_cnt), 32'hFFFF);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("sat_hold", 32'(sc_cnt), 32'hFFFF);
        sc_clr = 1'b1;
        @(negedge clk);
        chk("sat_clear_prio", 32'(sc_cnt), 32'(0));
        sc_clr = 1'b0; sc_inc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdp_frame_timer.md
# hdp_frame_timer

Parametrised HDP panel frame-timing generator that replaces the fixed 1280-line, 40-packet timing hard-coded in the LCD top level. It sits between the pixel FIFO (first-word-fall-through) and the HDP output pins. It generates valid, update, sync and invert timing for any line/packet geometry, pops the FIFO during data slots, and substitutes zero data on underflow while counting the events. Power sequencing and the SPI setup stay outside; they gate `i_enable`.

## Interface
- `DATA_WIDTH`, 32, HDP data bus width
- `PACKETS_PER_LINE`, 40, valid data packets per line
- `LINE_BLANK`, 4, zero-data, valid-low packets after each line (≥1)
- `LINES`, 1280, lines per frame
- `BACK_PORCH`, 24, blank cycles after the last line (≥1)
- `UPDATE_LEN`, 28, cycles `o_update` is high at frame start (< frame length)

Ports:
- `i_clock` in 1: single clock, all logic on the rising edge
- `i_nReset` in 1: asynchronous assert, active-low reset
- `i_enable` in 1: run frames continuously while high
- `i_clearStats` in 1: synchronous clear of the underflow count
- `i_fifoData` in DATA_WIDTH: FIFO head word (FWFT)
- `i_fifoEmpty` in 1: FIFO empty flag
- `o_fifoRead` out 1: combinational pop strobe
- `o_lcdData` out DATA_WIDTH: registered HDP data
- `o_valid`, `o_update`, `o_sync`, `o_invert` out 1: registered HDP controls
- `o_active` out 1: high while not IDLE
- `o_underflowCount` out 16: saturating underflow count

## Operation
- States: IDLE, ACTIVE (lines incl. blanking), PORCH.
- IDLE → ACTIVE when `i_enable`=1. All counters are zeroed on entry.
- ACTIVE uses `pkt` (0..PACKETS_PER_LINE+LINE_BLANK−1) and `line` (0..LINES−1). When `pkt` wraps, `line` increments. At the last packet of the last line the block goes to PORCH.
- PORCH counts BACK_PORCH cycles. At the end it goes to ACTIVE if `i_enable`=1, otherwise IDLE.
- `i_enable` is sampled only in IDLE and at the end of PORCH. Deassertion mid-frame lets the frame complete.
- Data slot: ACTIVE with `pkt` < PACKETS_PER_LINE.
  - `o_fifoRead` = slot && !`i_fifoEmpty`.
  - `o_lcdData` is registered from `i_fifoData` when the FIFO is read, else 0.
- Underflow: a slot with `i_fifoEmpty`=1. Output data is 0 and `o_valid` stays high. The count increments and saturates at 0xFFFF.
- `i_clearStats` takes priority over a same-cycle increment (result 0).
- `o_update` is high for the first UPDATE_LEN cycles of each frame, counted with a frame-cycle counter.
- `o_sync` is a one-cycle pulse on the first output cycle of each frame.
- Counter widths are `$clog2` of each range. The frame-cycle counter is wide enough for LINES×(PACKETS_PER_LINE+LINE_BLANK)+BACK_PORCH.

## Timing
- Reset: state IDLE, all counters 0. `o_lcdData`=0; `o_valid`, `o_update`, `o_sync`, `o_invert`, `o_active`, `o_fifoRead` all 0; `o_underflowCount`=0.
- `i_nReset` low mid-frame aborts the frame immediately. No porch is completed.
- Registered outputs lag the counter state by 1 cycle. A FIFO word popped in cycle N appears on `o_lcdData` with `o_valid` in cycle N+1.
- Frame length is exactly LINES×(PACKETS_PER_LINE+LINE_BLANK)+BACK_PORCH cycles.
- Back-to-back frames have no idle gap.
- First `o_valid` appears 2 cycles after `i_enable` rises in IDLE: 1 cycle for the state transition, 1 for the output register.
- `o_fifoRead` is never high outside a data slot, even if the FIFO is non-empty.

## Configuration
- `HDP_FRAME_INVERT_EN` defined: `o_invert` toggles at every frame start, registered and aligned with `o_sync`. It resets to 0, so frame 0 is 0 and frame 1 is 1.
- Not defined: `o_invert` is tied to 0 and no toggle flop exists.

## Structure
- Package `hdp_timing_pkg` holds:
  - the state enum (IDLE/ACTIVE/PORCH);
  - default geometry constants (1280 lines, 40+4 packets, porch 24, update 28);
  - a function computing frame length.
- One sub-module: `hdp_sat_counter`, a 16-bit saturating counter with increment and synchronous clear, used for the underflow count.

## Test plan
1. Geometry PACKETS_PER_LINE=4, LINE_BLANK=2, LINES=3, BACK_PORCH=5; FIFO always full; enable held → frame is 23 cycles; `o_valid` shows 4-high/2-low ×3 then 5 low; `o_sync` pulses every 23 cycles; 12 pops per frame.
2. Same geometry; FIFO empty for line 1 → 4 zero words with `o_valid`=1; `o_underflowCount`=4; `i_clearStats` in the same cycle as the next underflow → 0.
3. Force 70000 underflows → `o_underflowCount` holds 0xFFFF.
4. Drop `i_enable` at line 1 → frame completes through porch, then IDLE; `o_active`=0; no further pops.
5. Assert `i_nReset`=0 mid-line → all outputs 0 asynchronously; after release and enable, `o_sync` appears on the second cycle.
6. With `HDP_FRAME_INVERT_EN`, 4 frames → `o_invert` reads 0,1,0,1. Without it → constant 0. `o_update` is high for min(UPDATE_LEN, frame) cycles per frame.
